// File: rtl/ram_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : ram_stream_pkg                                               |
// | Description : Shared defaults for the RAM-backed stream FIFO controller:   |
// |               data/address widths, RAM depth and occupancy counter width.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ram_stream_pkg;

  localparam int DEF_DATA_WIDTH  = 5;
  localparam int DEF_ADDR_WIDTH  = 5;
  localparam int DEF_DEPTH       = 1 << DEF_ADDR_WIDTH;
  // One extra bit so that a completely full RAM (DEPTH entries) is representable.
  localparam int DEF_LEVEL_WIDTH = DEF_ADDR_WIDTH + 1;

endpackage : ram_stream_pkg
`default_nettype wire

// File: rtl/single_port_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : single_port_ram                                              |
// | Description : Single-port RAM, DEPTH = 2**ADDR_WIDTH words. Write when we=1;|
// |               synchronous read (out updates one cycle after addr, we=0).   |
// |               Contents are not reset.                                      |
// | Ports       : clk  - clock, rising edge                                    |
// |               data - write data                                            |
// |               addr - read/write address                                    |
// |               we   - write enable                                          |
// |               out  - registered read data                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module single_port_ram #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] out
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= data;
    end else begin
      out <= mem_q[addr];
    end
  end

endmodule : single_port_ram
`default_nettype wire

// File: rtl/ram_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_stream_ctrl                                              |
// | Description : Stream FIFO controller driving an external single-port RAM.  |
// |               Input valid/ready pushes become RAM writes; RAM reads feed a |
// |               registered valid/ready output. One RAM access per cycle,     |
// |               reads have priority over writes.                             |
// | Ports       : clk, rst            - clock, synchronous active-high reset   |
// |               in_data/valid/ready - push stream                            |
// |               out_data/valid/ready- pop stream (out_data registered)       |
// |               ram_data/addr/we    - RAM port drive                         |
// |               ram_out             - RAM read data (1-cycle latency)        |
// |               level               - entries held in RAM (not output reg)   |
// | Options     : RAM_STREAM_CTRL_BYPASS_EN - when nothing is buffered and the |
// |               output register is free, a push loads out_data directly.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram_stream_ctrl
  import ram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic [ADDR_WIDTH:0]   level
);

  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  rd_pending_q, rd_pending_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic w_out_fire;
  logic w_out_free;
  logic w_rd_go;
  logic w_byp_go;
  logic w_in_ready;
  logic w_wr_go;

  always_comb begin
    w_out_fire = out_valid_q && out_ready;
    // Output register can accept new data at this edge (empty or being popped).
    w_out_free = !out_valid_q || w_out_fire;
    // A read is only launched when its data is guaranteed a free output
    // register at the capture edge, so a capture never overwrites a value.
    w_rd_go    = (level_q != '0) && !rd_pending_q && w_out_free;
`ifdef RAM_STREAM_CTRL_BYPASS_EN
    w_byp_go   = (level_q == '0) && !rd_pending_q && w_out_free && in_valid;
`else
    w_byp_go   = 1'b0;
`endif
    // Read owns the port this cycle; in_ready never looks at in_valid.
    w_in_ready = !w_rd_go && (level_q != FULL_LEVEL);
    w_wr_go    = in_valid && w_in_ready && !w_byp_go;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    rd_pending_d = w_rd_go;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    if (w_wr_go) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      level_d  = level_q + 1'b1;
    end else if (w_rd_go) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      level_d  = level_q - 1'b1;
    end

    if (rd_pending_q) begin
      out_data_d  = ram_out;
      out_valid_d = 1'b1;
    end else if (w_byp_go) begin
      out_data_d  = in_data;
      out_valid_d = 1'b1;
    end else if (w_out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rd_pending_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rd_pending_q <= rd_pending_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  // Idle port parks the address on rd_ptr; data always mirrors the input.
  assign ram_we    = w_wr_go;
  assign ram_addr  = w_wr_go ? wr_ptr_q : rd_ptr_q;
  assign ram_data  = in_data;

  assign in_ready  = w_in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;

endmodule : ram_stream_ctrl
`default_nettype wire

// File: tb/tb_ram_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ram_stream_ctrl                                           |
// | Description : Self-checking bench for ram_stream_ctrl paired with          |
// |               single_port_ram. Accepted pushes go into a reference FIFO    |
// |               queue; a monitor pops it on every output handshake.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ram_stream_ctrl;

  localparam int DW = 5;
  localparam int AW = 5;
`ifdef RAM_STREAM_CTRL_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_out;
  logic [AW:0]   level;

  always #5 clk = ~clk;

  ram_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_out(ram_out), .level(level)
  );

  single_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_ram (
    .clk(clk), .data(ram_data), .addr(ram_addr), .we(ram_we), .out(ram_out)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp_v);
    total_cnt++;
    if (act == exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
  endtask

  // Scoreboard monitor: sampled at the falling edge, inputs are stable.
  initial begin : monitor
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_data", int'(out_data), int'(prev_data));
        end
        if (ram_we) check("we_only_on_push", int'(in_valid && in_ready), 1);
        if (in_valid && in_ready) exp_q.push_back(in_data);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_output", int'(out_data), -1);
          else check("fifo_order", int'(out_data), int'(exp_q.pop_front()));
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high; caller decides when to drop it.
  task automatic push(input logic [DW-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) break;
    end
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic wait_empty(input string tag);
    bit done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid && level == 0) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_drained"}, int'(done), 1);
    check({tag, "_level0"}, int'(level), 0);
    tick();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    int stamps [$];
    int bad;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_out_data", int'(out_data), 0);

    // Latency from a single push into an empty block
    tick();
    out_ready = 1'b1;
    in_data   = 5'h01;
    in_valid  = 1'b1;
    @(negedge clk);
    check("lat_push_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      tick();
    end
    check("latency", lat, EXP_LAT);
    check("lat_data", int'(out_data), 1);
    wait_empty("lat");

    // Fill to full with the consumer stalled
    out_ready = 1'b0;
    for (int v = 0; v < 32; v++) push(DW'(v));
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("fill_level31", int'(level), 31);
    check("fill_head_valid", int'(out_valid), 1);
    check("fill_head_data", int'(out_data), 0);
    tick();
    push(5'h15);
    in_valid = 1'b1;
    in_data  = 5'h0E;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_level32", int'(level), 32);
      check("full_in_ready", int'(in_ready), 0);
      check("full_ram_we", int'(ram_we), 0);
      tick();
    end
    in_valid = 1'b0;

    // Drain: one pop every two cycles
    out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) stamps.push_back(c);
      if (stamps.size() == 33) break;
      tick();
    end
    check("drain_count", stamps.size(), 33);
    bad = 0;
    for (int i = 1; i < stamps.size(); i++) if (stamps[i] - stamps[i-1] != 2) bad++;
    check("drain_gap2", bad, 0);
    wait_empty("drain");

    // Read wins the port: write stalls one cycle, proceeds the next
    out_ready = 1'b0;
    push(5'h03);
    push(5'h04);
    push(5'h05);
    in_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("stall_setup_level", int'(level), 2);
    check("stall_setup_valid", int'(out_valid), 1);
    tick();
    in_valid  = 1'b1;
    in_data   = 5'h06;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_in_ready", int'(in_ready), 0);
    check("stall_ram_we", int'(ram_we), 0);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("resume_in_ready", int'(in_ready), 1);
    check("resume_ram_we", int'(ram_we), 1);
    tick();
    in_valid = 1'b0;
    wait_empty("stall");

    // Continuous streaming with pointer wrap
    out_ready = 1'b1;
    for (int i = 0; i < 80; i++) push(DW'($urandom_range(0, 31)));
    in_valid = 1'b0;
    wait_empty("stream");

    // Reset in the middle of a read
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(DW'(16 + i));
    in_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("rstmid_setup_level", int'(level), 6);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_level5", int'(level), 5);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_out_valid", int'(out_valid), 0);
    check("rstmid_level", int'(level), 0);
    check("rstmid_in_ready", int'(in_ready), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("rstmid_no_pulse", int'(out_valid), 0);
    end
    tick();
    push(5'h0A);
    in_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = 1;
        break;
      end
      tick();
    end
    check("rstmid_first_seen", lat, 1);
    check("rstmid_first_data", int'(out_data), 10);
    tick();
    wait_empty("rstmid");

    // Consumer toggling ready every cycle
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(DW'($urandom_range(0, 31)));
    in_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      out_ready = ~out_ready;
      tick();
    end
    wait_empty("toggle");

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_ram_stream_ctrl
`default_nettype wire

// File: doc/ram_stream_ctrl.md
Name: ram_stream_ctrl

Overview:
- Upstream driver for the existing single_port_ram: converts a valid/ready input stream into RAM writes and RAM reads into a valid/ready output stream, forming a FIFO over one shared RAM port.
- Arbitrates the single port, one access per cycle, and tracks pointers and occupancy.
- The RAM is instantiated alongside this block, not inside it; this block drives its data/addr/we and consumes its out.

Parameters:
DATA_WIDTH, 5, stream and RAM data width
ADDR_WIDTH, 5, RAM address width; DEPTH = 2**ADDR_WIDTH entries (32)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_data  input  DATA_WIDTH  push data
in_valid  input  1  push request
in_ready  output  1  push accepted when in_valid && in_ready
out_data  output  DATA_WIDTH  pop data (registered)
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  consumer accepts; out_fire = out_valid && out_ready
ram_data  output  DATA_WIDTH  to RAM data
ram_addr  output  ADDR_WIDTH  to RAM addr
ram_we  output  1  to RAM we
ram_out  input  DATA_WIDTH  from RAM out; synchronous read, valid one cycle after addr presented with we=0
level  output  ADDR_WIDTH+1  entries held in RAM (excludes output register)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high. No other clocks or resets.
- Registered state: wr_ptr, rd_ptr (ADDR_WIDTH, wrap modulo DEPTH naturally), level, rd_pending, out_valid, out_data.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, rd_pending=0, out_valid=0, out_data=0. RAM contents are not cleared. An in-flight read is discarded.
- Read issue (rd_go), combinational: level!=0 && !rd_pending && (!out_valid || out_fire).
  - Effects: ram_addr=rd_ptr, ram_we=0; rd_ptr+1, level-1, rd_pending<=1.
- Read priority: rd_go wins the port. in_ready = !rd_go && (level!=DEPTH).
- Write (wr_go = in_valid && in_ready):
  - Drives ram_addr=wr_ptr, ram_data=in_data, ram_we=1; wr_ptr+1, level+1.
- Idle port: ram_we=0, ram_addr=rd_ptr, ram_data=in_data. ram_we is never high while rd_go is high.
- Capture: when rd_pending=1, at the clock edge out_data<=ram_out, out_valid<=1, rd_pending<=0.
- out_fire without a capture in the same edge: out_valid<=0.
- rd_pending implies the output register is empty at the capture edge, so no overwrite is possible.
- Latency, push to out_valid: push accepted in cycle N with empty block -> read issued in N+1 -> out_valid=1 in N+3.
- Sustained throughput: one pop per 2 cycles when the consumer is always ready.
- Full: level==DEPTH forces in_ready=0. Empty: level==0, no read issued.
- in_ready never depends on in_valid. Data ordering is strict FIFO.
- Reset asserted mid-burst: all state returns to reset values on that edge; no output pulse follows.

Optional Feature:
- Macro: RAM_STREAM_CTRL_BYPASS_EN.
- Defined:
  - When level==0 && !rd_pending && (!out_valid || out_fire) && in_valid, in_data loads out_data directly at the edge, out_valid<=1.
  - No RAM write and no level change for that push; in_ready=1 in that case.
  - Empty-block latency becomes 1 cycle (out_valid in N+1).
- Undefined: every push goes through the RAM; latency is 3 cycles as above.

Decomposition:
- Package ram_stream_pkg holds DATA_WIDTH/ADDR_WIDTH defaults (5/5), the DEPTH constant, and the level width.
- No sub-module; arbitration and output register stay in one module.
- The bench pairs this block with single_port_ram at the same widths.

Test Plan:
- Reset, then push 0x01 in cycle 0 with out_ready=1 -> out_valid=1 with out_data=0x01 in cycle 3 (cycle 1 with BYPASS_EN); level returns to 0.
- Push 32 values 0x00..0x1F with out_ready=0:
  - The first value moves to the output register; level stops at 31.
  - Push more until level==32 -> in_ready=0 thereafter.
  - Drain with out_ready=1 -> 0x00..0x1F in order, one per 2 cycles.
- Continuous in_valid with out_ready=1 across more than 64 items -> both pointers wrap past 31; all data in order; no loss or duplication.
- In a cycle with level!=0 and the output register freed -> ram_we=0 and in_ready=0 that cycle; write proceeds the next cycle.
- Assert rst while rd_pending=1 and level=5 -> next cycle: out_valid=0, level=0, in_ready=1; the following push of 0x0A is the first value output.
- out_ready toggling 1/0 each cycle over 10 items -> out_data stable while out_valid && !out_ready; sequence intact.
